// File: rtl/mdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// shifter and adder control codes, and default iteration counts.
package mdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_MUL  = 3'd2,
        ST_DPRE = 3'd3,
        ST_DSUB = 3'd4,
        ST_DCOR = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Shifter control codes
    localparam logic [1:0] SHIFT_RIGHT   = 2'b00;  // right by 2 (Booth step)
    localparam logic [1:0] SHIFT_RESTORE = 2'b01;  // left, take restored remainder
    localparam logic [1:0] SHIFT_LEFT0   = 2'b10;  // left, pad 0
    localparam logic [1:0] SHIFT_LEFT1   = 2'b11;  // left, pad 1 (quotient bit set)

    // Adder operation codes
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam int MUL_STEPS_DEF = 17;
    localparam int DIV_STEPS_DEF = 32;
    localparam int CNT_W_DEF     = 6;

endpackage

// File: rtl/mult_divid_control_if.sv
// Control/status bundle between the execute stage (master) and the
// multiply/divide sequencer (slave).
interface mult_divid_control_if;

    logic       start;
    logic       op;
    logic       signed_op;
    logic [1:0] mult_bits;
    logic       rem_neg;
    logic       divisor_zero;

    logic       init_we;
    logic       we;
    logic       we_sub;
    logic       shift;
    logic [1:0] shift_type;
    logic [1:0] alu_op;
    logic       alu_x2;
    logic       signed_lat;
    logic       busy;
    logic       done;
    logic       div_zero;

    modport master (
        output start, op, signed_op, mult_bits, rem_neg, divisor_zero,
        input  init_we, we, we_sub, shift, shift_type, alu_op, alu_x2,
               signed_lat, busy, done, div_zero
    );

    modport slave (
        input  start, op, signed_op, mult_bits, rem_neg, divisor_zero,
        output init_we, we, we_sub, shift, shift_type, alu_op, alu_x2,
               signed_lat, busy, done, div_zero
    );

endinterface

// File: rtl/mdiv_booth_recode.sv
// Radix-4 Booth recoder: maps {multiplier bit pair, previous bit} to an
// adder operation and a 2x-multiplicand select.
module mdiv_booth_recode
    import mdiv_pkg::*;
(
    input  logic [1:0] mult_bits_i,
    input  logic       prev_bit_i,
    output logic [1:0] alu_op_o,
    output logic       alu_x2_o
);

    // Decode the Booth digit {-2,-1,0,+1,+2} into operation and magnitude
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        alu_op_o = ALU_PASS;
        alu_x2_o = 1'b0;
        unique case ({mult_bits_i, prev_bit_i})
            3'b001, 3'b010: alu_op_o = ALU_ADD;
            3'b011: begin
                alu_op_o = ALU_ADD;
                alu_x2_o = 1'b1;
            end
            3'b100: begin
                alu_op_o = ALU_SUB;
                alu_x2_o = 1'b1;
            end
            3'b101, 3'b110: alu_op_o = ALU_SUB;
            default: alu_op_o = ALU_PASS;  // 000 / 111
        endcase
    end

endmodule

// File: rtl/mult_divid_control.sv
// Sequencer for the shared multiply/divide result register and adder.
// Runs radix-4 Booth multiply or restoring divide and reports busy/done.
// Optional feature: define MDIV_DIVZERO_EN to short-circuit divide by zero
// straight to DONE with div_zero flagged; otherwise div_zero is tied low.
module mult_divid_control
    import mdiv_pkg::*;
#(
    parameter int MUL_STEPS = MUL_STEPS_DEF,
    parameter int DIV_STEPS = DIV_STEPS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_divid_control_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prev_bit_q, prev_bit_d;
    logic               op_q, op_d;
    logic               signed_q, signed_d;
`ifdef MDIV_DIVZERO_EN
    logic               dz_q, dz_d;
`endif

    logic [1:0] booth_op;
    logic       booth_x2;

    logic       init_we, we, we_sub, shift, alu_x2, busy, done;
    logic [1:0] shift_type, alu_op;

    mdiv_booth_recode u_booth (
        .mult_bits_i (bus.mult_bits),
        .prev_bit_i  (prev_bit_q),
        .alu_op_o    (booth_op),
        .alu_x2_o    (booth_x2)
    );

    // State, counter and latched-operand registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prev_bit_q <= 1'b0;
            op_q       <= 1'b0;
            signed_q   <= 1'b0;
`ifdef MDIV_DIVZERO_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_bit_q <= prev_bit_d;
            op_q       <= op_d;
            signed_q   <= signed_d;
`ifdef MDIV_DIVZERO_EN
            dz_q       <= dz_d;
`endif
        end
    end

    // Next-state logic and per-state datapath strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_bit_d = prev_bit_q;
        op_d       = op_q;
        signed_d   = signed_q;
`ifdef MDIV_DIVZERO_EN
        dz_d       = dz_q;
`endif
        init_we    = 1'b0;
        we         = 1'b0;
        we_sub     = 1'b0;
        shift      = 1'b0;
        shift_type = SHIFT_RIGHT;
        alu_op     = ALU_PASS;
        alu_x2     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    signed_d = bus.signed_op;
                    state_d  = ST_INIT;
`ifdef MDIV_DIVZERO_EN
                    dz_d = ~bus.op & bus.divisor_zero;
                    if (dz_d) state_d = ST_DONE;
`endif
                end
            end
            ST_INIT: begin
                busy       = 1'b1;
                init_we    = 1'b1;
                cnt_d      = '0;
                prev_bit_d = 1'b0;
                state_d    = op_q ? ST_MUL : ST_DPRE;
            end
            ST_MUL: begin
                busy       = 1'b1;
                we         = 1'b1;
                shift      = 1'b1;
                shift_type = SHIFT_RIGHT;
                alu_op     = booth_op;
                alu_x2     = booth_x2;
                prev_bit_d = bus.mult_bits[1];
                // Exit is decided before incrementing, so cnt never passes the limit
                if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = ST_DONE;
                else                                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DPRE: begin
                busy       = 1'b1;
                we         = 1'b1;
                shift      = 1'b1;
                shift_type = SHIFT_LEFT0;
                state_d    = ST_DSUB;
            end
            ST_DSUB: begin
                busy    = 1'b1;
                we      = 1'b1;
                we_sub  = 1'b1;
                alu_op  = ALU_SUB;
                state_d = ST_DCOR;
            end
            ST_DCOR: begin
                busy  = 1'b1;
                we    = 1'b1;
                shift = 1'b1;
                // Negative trial remainder: add divisor back, quotient bit 0
                if (bus.rem_neg) begin
                    alu_op     = ALU_ADD;
                    shift_type = SHIFT_RESTORE;
                end else begin
                    alu_op     = ALU_PASS;
                    shift_type = SHIFT_LEFT1;
                end
                if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = ST_DONE;
                else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_DSUB;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.init_we    = init_we;
    assign bus.we         = we;
    assign bus.we_sub     = we_sub;
    assign bus.shift      = shift;
    assign bus.shift_type = shift_type;
    assign bus.alu_op     = alu_op;
    assign bus.alu_x2     = alu_x2;
    assign bus.signed_lat = signed_q;
    assign bus.busy       = busy;
    assign bus.done       = done;
`ifdef MDIV_DIVZERO_EN
    assign bus.div_zero   = (state_q == ST_DONE) & dz_q;
`else
    assign bus.div_zero   = 1'b0;
`endif

endmodule
